// File: rtl/sin_pkg.sv
// Shared constants and state type for the sine lookup path and its inverse.
package sin_pkg;
  localparam int SIN_ADDR_W  = 12;
  localparam int SIN_DATA_W  = 16;
  localparam int SIN_FRAC_W  = 2;
  localparam int SIN_PHASE_W = SIN_ADDR_W + SIN_FRAC_W;
  localparam int LATENCY     = 2 * SIN_ADDR_W + 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_FETCH0,
    ST_FETCH1,
    ST_FRAC,
    ST_DONE
  } sin_state_e;
endpackage

// File: rtl/sin_frac_cmp.sv
// Quarter-step fraction: how many of the three interpolated points between t0 and t1
// lie at or below v, clamped to 0 at the last table entry or when v is below t0.
module sin_frac_cmp
  import sin_pkg::*;
#(
  parameter int DATA_W = SIN_DATA_W
) (
  input  logic [DATA_W-1:0]     t0,
  input  logic [DATA_W-1:0]     t1,
  input  logic [DATA_W-1:0]     v,
  input  logic                  is_last,
  output logic [SIN_FRAC_W-1:0] frac
);
  logic [2:0] le;

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_step
      logic [DATA_W+1:0] sum;
      // Two extra bits hold 4*max without overflow before the divide by 4.
      assign sum = ({2'b00, t0} * (DATA_W+2)'(4 - gi)) + ({2'b00, t1} * (DATA_W+2)'(gi));
      assign le[gi-1] = (sum[DATA_W+1:2] <= v);
    end
  endgenerate

  always_comb begin
    frac = {1'b0, le[0]} + {1'b0, le[1]} + {1'b0, le[2]};
    if (is_last || (v < t0)) begin
      frac = '0;
    end
  end
endmodule

// File: rtl/sin_phase_inv.sv
// Inverse sine lookup: binary search over the ROM, then quarter-step interpolation.
// Define SIN_PHASE_INV_RANGE_EN to add the out_range flag.
module sin_phase_inv
  import sin_pkg::*;
#(
  parameter int ADDR_W = SIN_ADDR_W,
  parameter int DATA_W = SIN_DATA_W,
  parameter int FRAC_W = SIN_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_val,
  output logic [ADDR_W-1:0]        tbl_addr,
  input  logic [DATA_W-1:0]        tbl_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef SIN_PHASE_INV_RANGE_EN
  output logic                     out_range,
`endif
  output logic [ADDR_W+FRAC_W-1:0] out_phase
);
  localparam int BIT_W = $clog2(ADDR_W);

  sin_state_e                state_q, state_d;
  logic                      ph_q, ph_d;
  logic [DATA_W-1:0]         v_q, v_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [DATA_W-1:0]         t0_q, t0_d;
  logic [DATA_W-1:0]         t1_q, t1_d;
  logic [ADDR_W+FRAC_W-1:0]  phase_q, phase_d;
  logic [ADDR_W-1:0]         probe;
  logic                      at_max;
  logic [FRAC_W-1:0]         frac;
`ifdef SIN_PHASE_INV_RANGE_EN
  logic                      range_q, range_d;
`endif

  assign probe  = idx_q | (ADDR_W'(1) << bit_q);
  assign at_max = &idx_q;

  sin_frac_cmp #(.DATA_W(DATA_W)) u_frac (
    .t0      (t0_q),
    .t1      (t1_q),
    .v       (v_q),
    .is_last (at_max),
    .frac    (frac)
  );

  always_comb begin
    state_d  = state_q;
    ph_d     = 1'b0;
    v_d      = v_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    phase_d  = phase_q;
    tbl_addr = '0;
`ifdef SIN_PHASE_INV_RANGE_EN
    range_d  = range_q;
`endif
    // ph_q selects the address cycle (0) or the data-sample cycle (1) of each read.
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          v_d     = in_val;
          idx_d   = '0;
          bit_d   = BIT_W'(ADDR_W - 1);
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        tbl_addr = probe;
        ph_d     = ~ph_q;
        if (ph_q) begin
          if (tbl_data <= v_q) idx_d = probe;
          if (bit_q == '0) state_d = ST_FETCH0;
          else             bit_d   = bit_q - 1'b1;
        end
      end
      ST_FETCH0: begin
        tbl_addr = idx_q;
        ph_d     = ~ph_q;
        if (ph_q) begin
          t0_d    = tbl_data;
          state_d = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        tbl_addr = at_max ? idx_q : idx_q + 1'b1;
        ph_d     = ~ph_q;
        if (ph_q) begin
          t1_d    = tbl_data;
          state_d = ST_FRAC;
        end
      end
      ST_FRAC: begin
        phase_d = {idx_q, frac};
`ifdef SIN_PHASE_INV_RANGE_EN
        // t0 is table[0] when idx is 0 and table[max] when idx is max.
        range_d = ((idx_q == '0) && (v_q < t0_q)) || (at_max && (v_q > t0_q));
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= 1'b0;
      v_q     <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      phase_q <= '0;
`ifdef SIN_PHASE_INV_RANGE_EN
      range_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      phase_q <= phase_d;
`ifdef SIN_PHASE_INV_RANGE_EN
      range_q <= range_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_phase = phase_q;
`ifdef SIN_PHASE_INV_RANGE_EN
  assign out_range = range_q;
`endif
endmodule

// File: tb/tb_sin_phase_inv.sv
// Randomized bench for sin_phase_inv against a search/interpolation model over a ROM of i*16.
module tb_sin_phase_inv;
  import sin_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_val = '0;
  logic [11:0] tbl_addr;
  logic [15:0] tbl_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] out_phase;
`ifdef SIN_PHASE_INV_RANGE_EN
  logic        out_range;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  sin_phase_inv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SIN_PHASE_INV_RANGE_EN
    .out_range (out_range),
`endif
    .out_phase (out_phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tbl(input int i);
    return (i * 16) & 16'hFFFF;
  endfunction

  always @(posedge clk) tbl_data <= 16'(tbl(int'(tbl_addr)));

  // Largest index whose entry is <= v, then count interpolated quarter points <= v.
  function automatic int model_phase(input int v);
    int idx = 0;
    int t0, t1, frac;
    for (int i = 0; i < 4096; i++) if (tbl(i) <= v) idx = i;
    t0 = tbl(idx);
    t1 = tbl((idx < 4095) ? idx + 1 : 4095);
    frac = 0;
    if (idx != 4095 && v >= t0)
      for (int k = 1; k <= 3; k++) if ((((4 - k) * t0 + k * t1) / 4) <= v) frac++;
    return idx * 4 + frac;
  endfunction

  function automatic int model_range(input int v);
    return (v < tbl(0) || v > tbl(4095)) ? 1 : 0;
  endfunction

  function automatic int fwd(input int x);
    int i = x >> 2;
    int f = x & 3;
    int t0 = tbl(i);
    int t1 = tbl((i < 4095) ? i + 1 : 4095);
    return ((4 - f) * t0 + f * t1) / 4;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: expectations are queued at accept and checked when out_valid rises.
  int          exp_q[$];
  int          rng_q[$];
  int          acc_edge = 0;
  int          last_phase = -1;
  logic        prev_valid = 1'b0;
  logic        prev_oready = 1'b0;
  logic [13:0] prev_phase = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_phase", int'(out_phase), 0);
      check("rst_tbl_addr", int'(tbl_addr), 0);
      exp_q.delete();
      rng_q.delete();
      prev_valid = 1'b0;
      prev_oready = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          int e, r;
          e = exp_q.pop_front();
          r = rng_q.pop_front();
          check("phase", int'(out_phase), e);
          check("latency", cyc - acc_edge, LATENCY);
`ifdef SIN_PHASE_INV_RANGE_EN
          check("range", int'(out_range), r);
`endif
          last_phase = int'(out_phase);
          $display("[TB] op in_val=0x%04h phase=0x%04h exp=0x%04h lat=%0d rng=%0d",
                   dut.v_q, out_phase, e, cyc - acc_edge, r);
        end
      end
      if (out_valid && prev_valid && !prev_oready) begin
        check("hold_phase", int'(out_phase), int'(prev_phase));
        check("hold_in_ready", int'(in_ready), 0);
      end
      if (prev_valid && prev_oready) begin
        check("post_hs_in_ready", int'(in_ready), 1);
        check("post_hs_out_valid", int'(out_valid), 0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_phase(int'(in_val)));
        rng_q.push_back(model_range(int'(in_val)));
        acc_edge = cyc + 1;
      end
      prev_valid = out_valid;
      prev_oready = out_ready;
      prev_phase = out_phase;
    end
  end

  task automatic run_op(input logic [15:0] v, input int stall);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("ready_timeout", 0, 1);
    last_phase = -1;
    in_valid = 1'b1;
    in_val = v;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_val = 16'($urandom);
    n = 0;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    if (!out_valid) check("valid_timeout", 0, 1);
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    int x;
    // Model pins, hand-computed for table[i] = i*16.
    check("pin_0100", model_phase(16'h0100), 14'h0040);
    check("pin_0108", model_phase(16'h0108), 14'h0042);
    check("pin_0005", model_phase(16'h0005), 14'h0001);
    check("pin_FFFF", model_phase(16'hFFFF), 14'h3FFC);
    check("pin_rng_FFFF", model_range(16'hFFFF), 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h0100, 0); check("dir_0100", last_phase, 14'h0040);
    run_op(16'h0108, 0); check("dir_0108", last_phase, 14'h0042);
    run_op(16'h0005, 0); check("dir_0005", last_phase, 14'h0001);
    run_op(16'hFFFF, 0); check("dir_FFFF", last_phase, 14'h3FFC);
    run_op(16'h0000, 0); check("dir_0000", last_phase, 14'h0000);
    run_op(16'hFFF0, 0); check("dir_FFF0", last_phase, 14'h3FFC);
    run_op(16'h0110, 10); check("backpressure", last_phase, 14'h0044);

    // Abort an operation 12 cycles after accept.
    while (!in_ready) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_val = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_tbl_addr", int'(tbl_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    check("abort_no_valid", seen, 0);
    run_op(16'h0108, 0); check("after_abort", last_phase, 14'h0042);

    for (int i = 0; i < 120; i++) run_op(16'($urandom), int'($urandom_range(0, 3)));

    // Round trip through the forward model; top index only resolves frac 0.
    for (int i = 0; i < 150; i++) begin
      x = (i == 0) ? 0 : (i == 1) ? 14'h3FFC : (i == 2) ? 14'h3FFB : int'($urandom_range(0, 16'h3FFF));
      if ((x >> 2) == 4095) x = x & 16'h3FFC;
      run_op(16'(fwd(x)), 0);
      check("round_trip", last_phase, x);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
